alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  synchronous abort; drops any in-flight or held operation.
REQ-005 in_valid  input  1  an operation is offered.
REQ-006 in_ready  output  1  the unit can accept an operation this cycle.
REQ-007 alu_control  input  4  operation code: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 SLT, 6 SLTU, 7 AND, 8 OR, 9 XOR; 10-15 reserved.
REQ-008 op_a, op_b  input  XLEN each  operands.
REQ-009 out_valid  output  1  result is held and valid.
REQ-010 out_ready  input  1  the consumer takes the result.
REQ-011 result  output  XLEN  operation result.
REQ-012 zero  output  1  result == 0; valid while out_valid is high.

Function
REQ-013 The FSM shall have three states: IDLE, SHIFT and DONE.
REQ-014 in_ready shall be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise.
REQ-015 A transfer shall occur when in_valid&&in_ready; the operands and code are captured on that edge.
REQ-016 Non-shift codes (0,1,5-9) shall go to DONE with result registered, giving out_valid in the cycle after acceptance.
REQ-017 ADD and SUB shall be modulo 2^XLEN with no carry or overflow output; SLT shall be a signed compare and SLTU an unsigned compare, each producing 0 or 1 zero-extended.
REQ-018 Shift codes (2,3,4) shall use shamt=op_b[4:0] and ignore op_b[31:5].
REQ-019 If shamt=0, the unit shall go directly to DONE with result=op_a (latency 1).
REQ-020 If shamt>0, the unit shall enter SHIFT with work=op_a and cnt=shamt.
REQ-021 Each SHIFT cycle shall shift work by one bit (SRA replicates bit 31) and decrement cnt, moving to DONE on the edge where cnt reaches 0.
REQ-022 Shift latency from acceptance to out_valid shall equal shamt cycles (1 to 31).
REQ-023 Reserved codes shall complete in 1 cycle with result=0 and zero=1.
REQ-024 In DONE, out_valid, result and zero shall stay stable until out_ready=1.
REQ-025 In DONE with out_ready=1 and a new transfer in the same cycle, the unit shall go straight to the new operation's next state (back-to-back, one non-shift op per cycle).
REQ-026 In DONE with out_ready=1 and no new transfer, the unit shall return to IDLE.
REQ-027 in_valid arriving during SHIFT shall not be accepted, and the upstream shall hold it.
REQ-028 flush=1 shall force IDLE on the next edge from any state, discard the result, and take priority over a simultaneous transfer or out_ready.
REQ-029 out_valid shall be 0 in the cycle after a flush.
REQ-030 Outputs shall be registered or depend on state and out_ready only, with no combinational path from op_a, op_b or alu_control to result.

Reset
REQ-031 While rst=1, the unit shall be in IDLE with out_valid=0, result=0, zero=0, cnt=0 and work=0, and in_ready shall be 1 after reset release.
REQ-032 Reset asserted mid-SHIFT or in DONE shall drop the operation immediately and asynchronously, with no partial result visible afterwards.

Structure
REQ-033 The 4-bit alu_control encodings shall be named constants in a shared package alu_pkg, also used by the existing ALU control decoder, together with the FSM state enumeration.
REQ-034 The single-cycle datapath (ADD/SUB/compare/logic) shall be one combinational sub-module alu_comb_core; the iterative shifter and FSM shall remain in alu_exec_unit.

Verification
REQ-035 ADD: a=0xFFFFFFFF, b=1 -> one cycle later out_valid=1, result=0, zero=1.
REQ-036 SLT vs SLTU: a=0xFFFFFFFF, b=1 -> SLT result=1, SLTU result=0.
REQ-037 SRA: a=0x80000000, b=0x0000001F -> out_valid exactly 31 cycles after acceptance, result=0xFFFFFFFF, with in_ready=0 throughout; SLL with b=0x20 (shamt 0) -> result=a after 1 cycle.
REQ-038 Backpressure plus back-to-back: hold out_ready=0 for 5 cycles -> result stable; release out_ready with in_valid=1 on the same cycle -> next XOR result valid the following cycle, no op lost or duplicated.
REQ-039 Flush at SHIFT cycle 3 of SRL by 10 -> IDLE next cycle, out_valid never asserted for that op; same test repeated with rst instead -> immediate IDLE and all outputs 0.
REQ-040 Reserved code 0xC, a=5, b=7 -> result=0, zero=1, latency 1; random mix of 1000 ops vs. reference model with random out_ready -> all results match, in order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, execution-unit FSM states and
// small decode helpers used by the execution unit and the control decoder.
package alu_pkg;

    localparam int ALU_XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SRL  = 4'd3;
    localparam logic [3:0] ALU_SRA  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } exec_state_e;

    function automatic logic isShiftOp(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

    // Codes 10-15 are reserved and complete as a zero result.
    function automatic logic isReservedOp(input logic [3:0] code);
        return code > ALU_XOR;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Valid/ready operation and result channels of the ALU execution unit.
// The master drives operations and consumes results; the slave is the unit.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output flush, in_valid, alu_control, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  flush, in_valid, alu_control, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle combinational datapath: add/sub, signed/unsigned compare and
// bitwise logic. Shift and reserved codes yield zero here.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alu_control_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (alu_control_i)
            ALU_ADD:  result_o = op_a_i + op_b_i;
            ALU_SUB:  result_o = op_a_i - op_b_i;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
            ALU_AND:  result_o = op_a_i & op_b_i;
            ALU_OR:   result_o = op_a_i | op_b_i;
            ALU_XOR:  result_o = op_a_i ^ op_b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready operation intake, single-cycle ops via
// alu_comb_core, and a one-bit-per-cycle iterative shifter with a held result.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);

    exec_state_e     state_q, state_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;

    logic [XLEN-1:0] coreResult;
    logic [XLEN-1:0] firstShift;
    logic [XLEN-1:0] workShift;
    logic [XLEN-1:0] singleResult;
    logic [4:0]      shamt;
    logic            inReady;
    logic            accept;

    function automatic logic [XLEN-1:0] shiftOne(input logic [3:0] code,
                                                 input logic [XLEN-1:0] value);
        logic [XLEN-1:0] shifted;
        case (code)
            ALU_SLL: shifted = {value[XLEN-2:0], 1'b0};
            ALU_SRA: shifted = {value[XLEN-1], value[XLEN-1:1]};
            default: shifted = {1'b0, value[XLEN-1:1]};
        endcase
        return shifted;
    endfunction

    alu_comb_core #(
        .XLEN(XLEN)
    ) u_core (
        .alu_control_i(bus.alu_control),
        .op_a_i       (bus.op_a),
        .op_b_i       (bus.op_b),
        .result_o     (coreResult)
    );

    assign shamt      = bus.op_b[4:0];
    assign firstShift = shiftOne(bus.alu_control, bus.op_a);
    assign workShift  = shiftOne(op_q, work_q);

    // Result for any op that finishes on the accepting edge.
    always_comb begin
        singleResult = coreResult;
        if (isShiftOp(bus.alu_control)) begin
            singleResult = (shamt == 5'd0) ? bus.op_a : firstShift;
        end else if (isReservedOp(bus.alu_control)) begin
            singleResult = '0;
        end
    end

    assign inReady       = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept        = bus.in_valid && inReady;
    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

    // The first shift step happens on the accepting edge, so a shift by N
    // presents its result N cycles after acceptance.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;

        if (bus.flush) begin
            state_d  = ST_IDLE;
            work_d   = '0;
            cnt_d    = '0;
            result_d = '0;
            zero_d   = 1'b0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    work_d = workShift;
                    cnt_d  = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d  = ST_DONE;
                        result_d = workShift;
                        zero_d   = (workShift == '0);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase

            if (accept) begin
                op_d    = bus.alu_control;
                state_d = ST_DONE;
                work_d  = '0;
                cnt_d   = '0;
                if (isShiftOp(bus.alu_control) && (shamt > 5'd1)) begin
                    state_d = ST_SHIFT;
                    work_d  = firstShift;
                    cnt_d   = shamt - 5'd1;
                end else begin
                    result_d = singleResult;
                    zero_d   = (singleResult == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            op_q     <= ALU_ADD;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule
